hex_scan_driver: RTL and testbench
==================================

Name: hex_scan_driver

Overview:
- Time-multiplexed scan driver placed directly upstream of the per-segment hex decoders (segments A..G).
- Accepts a frame of NUM_DIGITS hex nibbles through a valid/ready load handshake and holds it in a pending buffer.
- Commits the pending frame only at a frame boundary, so the display never shows a mix of old and new digits.
- Each cycle it presents one nibble on nibble_out, which is shared by all segment decoders, together with a one-hot digit enable. Dead time between digits prevents ghosting.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DIGIT_TICKS, 4, clock cycles each digit is driven (>=1).
- DEAD_TICKS, 1, clock cycles with all enables off after each digit (>=0; 0 means no dead phase).
- TICK_W, 16, width of the phase counter; must hold max(DIGIT_TICKS, DEAD_TICKS).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  frame valid; accepted only in a cycle where ready=1.
- data_in  input  4*NUM_DIGITS  digit i = data_in[4i+3:4i].
- blank_in  input  NUM_DIGITS  per-digit blank request, captured together with data_in.
- ready  output  1  pending buffer empty, so a load will be accepted.
- nibble_out  output  4  current digit value; bit3 feeds decoder in1 (MSB), bit0 feeds in4.
- digit_en  output  NUM_DIGITS  one-hot active-high enable, or all zero.
- blank_out  output  1  high whenever no digit is enabled.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- All outputs are registered.
- Reset values (asynchronous):
  - state=START, idx=0, tick=0.
  - display and pending data = 0, display blank = all 1, pending_valid=0.
  - ready=1, nibble_out=0, digit_en=0, blank_out=1, frame_done=0.
- FSM states: START, ON, DEAD.
- START: lasts one cycle after reset is released, then goes to ON with idx=0 and tick=0.
- ON:
  - digit_en = one-hot(idx), unless display blank[idx]=1, in which case digit_en=0.
  - nibble_out = display[idx].
  - blank_out = ~|digit_en.
  - tick counts 0..DIGIT_TICKS-1. At the last tick: go to DEAD if DEAD_TICKS>0, otherwise advance directly.
- DEAD:
  - digit_en=0, blank_out=1, nibble_out holds its last value.
  - tick counts 0..DEAD_TICKS-1, then advance.
- Advance:
  - If idx<NUM_DIGITS-1: idx+1.
  - If idx=NUM_DIGITS-1: idx wraps to 0, frame_done=1 for one cycle (the cycle in which ON for digit 0 begins), and commit runs.
- Slot length is DIGIT_TICKS+DEAD_TICKS cycles. Frame length is NUM_DIGITS times the slot length.
- Load handshake:
  - When load=1 and ready=1 at a clock edge: pending <= {data_in, blank_in}, pending_valid <= 1, ready <= 0.
  - load while ready=0 is ignored and nothing is stored.
- Commit (at wrap only):
  - If pending_valid: display <= pending, pending_valid <= 0, ready <= 1.
  - The new frame is visible starting at digit 0 of the next frame.
- Simultaneous load and commit cannot occur, because ready=0 while pending_valid=1. At most one frame is buffered.
- Back-to-back: after a commit, ready=1 from the next cycle on, so a new load is accepted no earlier than the cycle after the commit.
- Reset mid-scan or mid-handshake:
  - All state and outputs return to reset values immediately (asynchronously), and the pending frame is discarded.
  - Scanning resumes via START on the first edge after rst falls.
- Counters are unsigned and modulo-free: idx ranges over [0, NUM_DIGITS-1] and tick over [0, max-1]. No other values are reachable.

Test Plan (NUM_DIGITS=4, DIGIT_TICKS=4, DEAD_TICKS=1, slot=5, frame=20):
- Reset, release, no load -> one START cycle, then digit_en=0 throughout (display blank = 1111). frame_done pulses every 20 cycles. ready=1 throughout.
- Load data_in=16'h9A3F, blank_in=0000 during frame 1 -> ready=0 the next cycle. Display changes only after wrap. Then digit_en cycles 0001, 0010, 0100, 1000 for 4 cycles each with a 1-cycle 0000 gap, and nibble_out is F, 3, A, 9. ready=1 in the cycle after the commit.
- Second load while ready=0 (data_in=16'h1234) -> ignored. Display stays 9A3F after the next two commits.
- blank_in=0100 with data_in=16'h0008 -> digit 2 slot shows digit_en=0000, blank_out=1 for all 5 cycles. The other digits are driven normally.
- Load asserted in the exact cycle ready rises after a commit -> accepted, and shown one frame later.
- Assert rst mid-slot of digit 2 with a pending load -> digit_en=0 and ready=1 immediately. After release: START, then digit 0 with nibble 0 and display blank, and the pending frame never appears.

Source files
------------

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed hex digit scanner with a double-buffered frame load.
// Ports: clk/rst (async active-high); load/data_in/blank_in/ready form the frame
// load handshake; nibble_out/digit_en/blank_out drive the shared segment decoders;
// frame_done pulses once per full scan.
module hex_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 4,
  parameter int DEAD_TICKS  = 1,
  parameter int TICK_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic                    ready,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    blank_out,
  output logic                    frame_done
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [TICK_W-1:0] ON_LAST = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0] DEAD_LAST = TICK_W'(DEAD_TICKS > 0 ? DEAD_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {START, ON, DEAD} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0] dblank_q, dblank_d, pblank_q, pblank_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [3:0] nib_q, nib_d;
  logic pend_valid_q, pend_valid_d, ready_q, ready_d, blank_q, blank_d, fd_q, fd_d;
  logic advance, wrap, commit, accept;
  always_comb begin
    advance = (state_q == ON && tick_q == ON_LAST && DEAD_TICKS == 0) ||
              (state_q == DEAD && tick_q == DEAD_LAST);
    wrap = advance && idx_q == IDX_LAST;
    state_d = (state_q == START || advance) ? ON :
              (state_q == ON && tick_q == ON_LAST) ? DEAD : state_q;
    // every phase change (and a same-state ON->ON advance) restarts the phase counter
    tick_d = (state_d != state_q || advance) ? '0 : tick_q + TICK_W'(1);
    idx_d = (state_q == START || wrap) ? '0 : advance ? idx_q + IDX_W'(1) : idx_q;
    commit = wrap && pend_valid_q;
    accept = load && ready_q;
    disp_d = commit ? pend_q : disp_q;
    dblank_d = commit ? pblank_q : dblank_q;
    pend_d = accept ? data_in : pend_q;
    pblank_d = accept ? blank_in : pblank_q;
    pend_valid_d = accept || (pend_valid_q && !commit);
    ready_d = !pend_valid_d;
    // outputs decode the next state so they line up with the phase they describe,
    // and a just-committed frame is already visible on digit 0
    en_d = (state_d == ON && !dblank_d[idx_d]) ? NUM_DIGITS'(1) << idx_d : '0;
    nib_d = state_d == ON ? disp_d[idx_d] : nib_q;
    blank_d = ~|en_d;
    fd_d = wrap;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
      idx_q <= '0;
      tick_q <= '0;
      disp_q <= '0;
      dblank_q <= '1;
      pend_q <= '0;
      pblank_q <= '0;
      pend_valid_q <= 1'b0;
      ready_q <= 1'b1;
      nib_q <= '0;
      en_q <= '0;
      blank_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      tick_q <= tick_d;
      disp_q <= disp_d;
      dblank_q <= dblank_d;
      pend_q <= pend_d;
      pblank_q <= pblank_d;
      pend_valid_q <= pend_valid_d;
      ready_q <= ready_d;
      nib_q <= nib_d;
      en_q <= en_d;
      blank_q <= blank_d;
      fd_q <= fd_d;
    end
  end
  assign ready = ready_q;
  assign nibble_out = nib_q;
  assign digit_en = en_q;
  assign blank_out = blank_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_hex_scan_driver.sv
// tb_hex_scan_driver: directed and random checks of hex_scan_driver against a frame/slot timing model.
module tb_hex_scan_driver;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] blank_in = '0;
  logic ready, blank_out, frame_done;
  logic [3:0] nibble_out, digit_en;
  int tests = 0, fails = 0;
  int t;
  logic [15:0] m_disp, m_pend;
  logic [3:0] m_dblank, m_pblank;
  logic m_pv, m_ready;
  hex_scan_driver #(.NUM_DIGITS(4), .DIGIT_TICKS(4), .DEAD_TICKS(1), .TICK_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .blank_in(blank_in),
    .ready(ready), .nibble_out(nibble_out), .digit_en(digit_en),
    .blank_out(blank_out), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  // t counts edges since scanning started (-1 = reset/START); slot = 5 cycles, frame = 20
  task automatic chk();
    logic [3:0] e_en, e_nib;
    logic e_fd;
    int p, s;
    if (t < 0) begin
      e_en = '0;
      e_nib = '0;
      e_fd = 1'b0;
    end else begin
      p = t % 20;
      s = p / 5;
      e_en = (p % 5 < 4 && !m_dblank[s]) ? 4'(1 << s) : 4'b0;
      e_nib = m_disp[s*4 +: 4];
      e_fd = t > 0 && p == 0;
    end
    tests++;
    assert (digit_en === e_en) else begin fails++; $error("FAIL digit_en t=%0d got %b exp %b", t, digit_en, e_en); end
    tests++;
    assert (nibble_out === e_nib) else begin fails++; $error("FAIL nibble_out t=%0d got %h exp %h", t, nibble_out, e_nib); end
    tests++;
    assert (blank_out === (e_en == 4'b0)) else begin fails++; $error("FAIL blank_out t=%0d got %b exp %b", t, blank_out, e_en == 4'b0); end
    tests++;
    assert (frame_done === e_fd) else begin fails++; $error("FAIL frame_done t=%0d got %b exp %b", t, frame_done, e_fd); end
    tests++;
    assert (ready === m_ready) else begin fails++; $error("FAIL ready t=%0d got %b exp %b", t, ready, m_ready); end
  endtask
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] b);
    logic accept;
    load = ld;
    data_in = d;
    blank_in = b;
    @(posedge clk);
    accept = ld && m_ready;
    t++;
    if (t > 0 && t % 20 == 0 && m_pv) begin
      m_disp = m_pend;
      m_dblank = m_pblank;
      m_pv = 1'b0;
      m_ready = 1'b1;
    end
    if (accept) begin
      m_pend = d;
      m_pblank = b;
      m_pv = 1'b1;
      m_ready = 1'b0;
    end
    #1 chk();
  endtask
  task automatic do_reset();
    load = 1'b0;
    rst = 1'b1;
    #1;
    t = -1;
    m_disp = '0;
    m_dblank = '1;
    m_pend = '0;
    m_pblank = '0;
    m_pv = 1'b0;
    m_ready = 1'b1;
    chk();
    repeat (2) @(posedge clk);
    #1 chk();
    rst = 1'b0;
    chk();
  endtask
  initial begin
    do_reset();
    repeat (45) step(1'b0, '0, '0);
    step(1'b1, 16'h9A3F, 4'b0000);
    repeat (3) step(1'b1, 16'h1234, 4'b1111);
    repeat (60) step(1'b0, '0, '0);
    step(1'b1, 16'h0008, 4'b0100);
    for (int i = 0; i < 40 && !m_ready; i++) step(1'b0, '0, '0);
    step(1'b1, 16'($urandom), 4'b0000);
    repeat (45) step(1'b0, '0, '0);
    repeat (300) step($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom));
    for (int i = 0; i < 100 && !(t % 20 == 11 && m_pv); i++) step(m_ready, 16'($urandom), 4'($urandom));
    do_reset();
    repeat (45) step(1'b0, '0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
